// File: rtl/tlb_op_controller.sv
// TLB management-operation sequencer: probe, indexed read/write, random write and
// invalidate-all against external key/value memories, sharing the search port with translation.
module tlb_op_controller #(
  parameter int unsigned FIXED_ENTRIES = 4,
  parameter logic [19:0] INVALID_KEY   = 20'hC0000
) (
  input  logic        clock,
  input  logic        resetN,
  input  logic        cmdValid,
  output logic        cmdReady,
  input  logic [2:0]  cmdOp,
  input  logic [4:0]  cmdIndex,
  input  logic [19:0] cmdKey,
  input  logic [21:0] cmdValue,
  output logic        rspValid,
  input  logic        rspReady,
  output logic        rspFound,
  output logic [4:0]  rspIndex,
  output logic [19:0] rspKey,
  output logic [21:0] rspValue,
  input  logic [19:0] translateKey,
  output logic        translateStall,
  output logic [4:0]  keyAccessIndex,
  input  logic [19:0] keyReadValue,
  output logic [19:0] keyWriteValue,
  output logic        keyWriteEnable,
  output logic [19:0] keySearchKey,
  input  logic        keyFound,
  input  logic [4:0]  keyFoundIndex,
  output logic [4:0]  valueAccessIndex,
  input  logic [21:0] valueReadValue,
  output logic [21:0] valueWriteValue,
  output logic        valueWriteEnable,
  output logic [4:0]  randomIndex
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    FLUSH,
    RESP
  } state_t;

  localparam logic [2:0] OP_PROBE        = 3'd0;
  localparam logic [2:0] OP_READ         = 3'd1;
  localparam logic [2:0] OP_WRITE        = 3'd2;
  localparam logic [2:0] OP_WRITE_RANDOM = 3'd3;
  localparam logic [2:0] OP_INVALIDATE   = 3'd4;

  localparam logic [4:0] LAST_IDX  = '1;
  localparam logic [4:0] FIXED_IDX = 5'(FIXED_ENTRIES);

  state_t      r_state;
  state_t      w_nextState;
  logic [2:0]  r_op;
  logic [4:0]  r_index;
  logic [19:0] r_key;
  logic [21:0] r_value;
  logic [4:0]  r_flushCnt;
  logic [4:0]  r_random;
  logic        r_rspFound;
  logic [4:0]  r_rspIndex;
  logic [19:0] r_rspKey;
  logic [21:0] r_rspValue;
  logic        w_writeEn;

  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (cmdValid) begin
          if (cmdOp <= OP_WRITE_RANDOM) begin
            w_nextState = EXEC;
          end else if (cmdOp == OP_INVALIDATE) begin
            w_nextState = FLUSH;
          end else begin
            w_nextState = RESP;
          end
        end
      end
      EXEC:  w_nextState = RESP;
      FLUSH: begin
        if (r_flushCnt == LAST_IDX) begin
          w_nextState = RESP;
        end
      end
      RESP: begin
        if (rspReady) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    keyAccessIndex  = r_index;
    keyWriteValue   = r_key;
    valueWriteValue = r_value;
    keySearchKey    = translateKey;
    translateStall  = 1'b0;
    w_writeEn       = 1'b0;
    case (r_state)
      EXEC: begin
        case (r_op)
          OP_PROBE: begin
            keySearchKey   = r_key;
            translateStall = 1'b1;
          end
          OP_WRITE: begin
            w_writeEn = 1'b1;
          end
          OP_WRITE_RANDOM: begin
            keyAccessIndex = r_random;
            w_writeEn      = 1'b1;
          end
          default: ;
        endcase
      end
      FLUSH: begin
        keyAccessIndex  = r_flushCnt;
        keyWriteValue   = INVALID_KEY;
        valueWriteValue = '0;
        w_writeEn       = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are qualified by resetN so the edge that resets a flush commits no write.
  assign keyWriteEnable   = w_writeEn & resetN;
  assign valueWriteEnable = w_writeEn & resetN;
  assign valueAccessIndex = keyAccessIndex;

  assign cmdReady    = (r_state == IDLE);
  assign rspValid    = (r_state == RESP);
  assign rspFound    = r_rspFound;
  assign rspIndex    = r_rspIndex;
  assign rspKey      = r_rspKey;
  assign rspValue    = r_rspValue;
  assign randomIndex = r_random;

  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_op       <= '0;
      r_index    <= '0;
      r_key      <= '0;
      r_value    <= '0;
      r_flushCnt <= '0;
      r_rspFound <= 1'b0;
      r_rspIndex <= '0;
      r_rspKey   <= '0;
      r_rspValue <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmdValid) begin
            r_op       <= cmdOp;
            r_index    <= cmdIndex;
            r_key      <= cmdKey;
            r_value    <= cmdValue;
            r_flushCnt <= '0;
            r_rspFound <= 1'b0;
            r_rspIndex <= '0;
            r_rspKey   <= '0;
            r_rspValue <= '0;
          end
        end
        EXEC: begin
          case (r_op)
            OP_PROBE: begin
              r_rspFound <= keyFound;
              r_rspIndex <= keyFound ? keyFoundIndex : '0;
            end
            OP_READ: begin
              r_rspKey   <= keyReadValue;
              r_rspValue <= valueReadValue;
              r_rspIndex <= r_index;
            end
            OP_WRITE:        r_rspIndex <= r_index;
            OP_WRITE_RANDOM: r_rspIndex <= r_random;
            default: ;
          endcase
        end
        FLUSH: begin
          r_flushCnt <= r_flushCnt + 5'd1;
          if (r_flushCnt == LAST_IDX) begin
            r_rspIndex <= LAST_IDX;
          end
        end
        default: ;
      endcase
    end
  end

  // Free-running replacement pointer, cycling 31 down to FIXED_ENTRIES.
  always_ff @(posedge clock) begin
    if (!resetN) begin
      r_random <= '1;
    end else if (r_random == FIXED_IDX) begin
      r_random <= '1;
    end else begin
      r_random <= r_random - 5'd1;
    end
  end

endmodule

// File: tb/tb_tlb_op_controller.sv
// Scoreboard bench for tlb_op_controller with a behavioural key/value memory and a
// reference TLB model; random and directed management traffic.
module tb_tlb_op_controller;

  localparam int          FIXED = 4;
  localparam logic [19:0] INV   = 20'hC0000;

  logic        clock;
  logic        resetN;
  logic        cmdValid;
  logic        cmdReady;
  logic [2:0]  cmdOp;
  logic [4:0]  cmdIndex;
  logic [19:0] cmdKey;
  logic [21:0] cmdValue;
  logic        rspValid;
  logic        rspReady;
  logic        rspFound;
  logic [4:0]  rspIndex;
  logic [19:0] rspKey;
  logic [21:0] rspValue;
  logic [19:0] translateKey;
  logic        translateStall;
  logic [4:0]  keyAccessIndex;
  logic [19:0] keyReadValue;
  logic [19:0] keyWriteValue;
  logic        keyWriteEnable;
  logic [19:0] keySearchKey;
  logic        keyFound;
  logic [4:0]  keyFoundIndex;
  logic [4:0]  valueAccessIndex;
  logic [21:0] valueReadValue;
  logic [21:0] valueWriteValue;
  logic        valueWriteEnable;
  logic [4:0]  randomIndex;

  tlb_op_controller #(.FIXED_ENTRIES(FIXED), .INVALID_KEY(INV)) dut (
    .clock(clock), .resetN(resetN),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp), .cmdIndex(cmdIndex),
    .cmdKey(cmdKey), .cmdValue(cmdValue),
    .rspValid(rspValid), .rspReady(rspReady), .rspFound(rspFound), .rspIndex(rspIndex),
    .rspKey(rspKey), .rspValue(rspValue),
    .translateKey(translateKey), .translateStall(translateStall),
    .keyAccessIndex(keyAccessIndex), .keyReadValue(keyReadValue),
    .keyWriteValue(keyWriteValue), .keyWriteEnable(keyWriteEnable),
    .keySearchKey(keySearchKey), .keyFound(keyFound), .keyFoundIndex(keyFoundIndex),
    .valueAccessIndex(valueAccessIndex), .valueReadValue(valueReadValue),
    .valueWriteValue(valueWriteValue), .valueWriteEnable(valueWriteEnable),
    .randomIndex(randomIndex)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0]  op;
    logic        found;
    logic [4:0]  idx;
    logic [19:0] key;
    logic [21:0] val;
  } rsp_t;

  typedef struct packed {
    logic [4:0]  idx;
    logic [19:0] key;
    logic [21:0] val;
  } wr_t;

  rsp_t        rq[$];
  wr_t         wq[$];
  logic [19:0] ref_key[32];
  logic [21:0] ref_val[32];
  logic [19:0] mem_key[32];
  logic [21:0] mem_val[32];
  logic        tb_load;
  int          cyc = -1;
  int          errors = 0;
  int          checks = 0;
  int          rsp_exp = 0;
  int          rsp_seen = 0;
  logic [2:0]  cur_op = 3'd0;
  logic        hold_low = 1'b0;

  // Storage environment: async read, sync write, lowest-index search.
  always @(posedge clock) begin
    if (tb_load) begin
      for (int i = 0; i < 32; i++) begin
        mem_key[i] <= ref_key[i];
        mem_val[i] <= ref_val[i];
      end
    end else begin
      if (keyWriteEnable)   mem_key[keyAccessIndex]   <= keyWriteValue;
      if (valueWriteEnable) mem_val[valueAccessIndex] <= valueWriteValue;
    end
  end

  assign keyReadValue   = mem_key[keyAccessIndex];
  assign valueReadValue = mem_val[valueAccessIndex];

  always_comb begin
    keyFound      = 1'b0;
    keyFoundIndex = '0;
    for (int i = 31; i >= 0; i--) begin
      if (mem_key[i] == keySearchKey) begin
        keyFound      = 1'b1;
        keyFoundIndex = 5'(i);
      end
    end
  end

  always @(posedge clock) begin
    if (!resetN) cyc <= 0;
    else if (cyc >= 0) cyc <= cyc + 1;
  end

  function automatic logic [4:0] exp_rand(input int c);
    return 5'(31 - (c % (32 - FIXED)));
  endfunction

  function automatic int ref_search(input logic [19:0] k);
    for (int i = 0; i < 32; i++) begin
      if (ref_key[i] == k) return i;
    end
    return -1;
  endfunction

  function automatic logic [19:0] rand_key();
    logic [19:0] k;
    do k = 20'($urandom); while (k == 20'h12345 || k == 20'h55555 || k == INV);
    return k;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : drv_side
    rspReady     = 1'b0;
    translateKey = '0;
    forever begin
      @(posedge clock);
      #1;
      translateKey = 20'($urandom);
      rspReady     = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : monitor
    logic        hold = 1'b0;
    logic [47:0] prev = '0;
    rsp_t        e;
    wr_t         w;
    forever begin
      @(negedge clock);
      if (cyc >= 0) chk("random_index", 32'(randomIndex), 32'(exp_rand(cyc)));
      if (keyWriteEnable || valueWriteEnable) begin
        chk("we_pair", 32'({keyWriteEnable, valueWriteEnable}), 32'(2'b11));
        chk("access_idx_pair", 32'(valueAccessIndex), 32'(keyAccessIndex));
        chk("stall_during_write", 32'(translateStall), 32'd0);
        if (cur_op == 3'd3) chk("rand_write_floor", 32'(keyAccessIndex >= 5'(FIXED)), 32'd1);
        if (wq.size() == 0) begin
          chk("unexpected_write", 32'(keyAccessIndex), 32'hFFFF_FFFF);
        end else begin
          w = wq.pop_front();
          chk("write_idx", 32'(keyAccessIndex), 32'(w.idx));
          chk("write_key", 32'(keyWriteValue), 32'(w.key));
          chk("write_val", 32'(valueWriteValue), 32'(w.val));
        end
      end
      if (rspValid) begin
        if (hold) chk("rsp_stable", 32'({rspFound, rspIndex, rspKey, rspValue} != prev), 32'd0);
        if (rspReady) begin
          if (rq.size() == 0) begin
            chk("unexpected_rsp", 32'(rspIndex), 32'hFFFF_FFFF);
          end else begin
            e = rq.pop_front();
            chk("rsp_index", 32'(rspIndex), 32'(e.idx));
            if (e.op == 3'd0 || e.op >= 3'd5) chk("rsp_found", 32'(rspFound), 32'(e.found));
            if (e.op == 3'd1) begin
              chk("rsp_key", 32'(rspKey), 32'(e.key));
              chk("rsp_value", 32'(rspValue), 32'(e.val));
            end
          end
          rsp_seen++;
        end
        hold = !rspReady;
        prev = {rspFound, rspIndex, rspKey, rspValue};
      end else begin
        if (hold) chk("rsp_withdrawn", 32'(rspValid), 32'd1);
        hold = 1'b0;
      end
    end
  end

  // Issue one command (called just after a negedge) and record its expected effects.
  task automatic send(input logic [2:0] op, input logic [4:0] idx,
                      input logic [19:0] key, input logic [21:0] val);
    int   n = 0;
    int   s;
    rsp_t e;
    cmdValid = 1'b1;
    cmdOp    = op;
    cmdIndex = idx;
    cmdKey   = key;
    cmdValue = val;
    while (!cmdReady && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("cmd_accept", 32'(cmdReady), 32'd1);
    if (!cmdReady) begin
      cmdValid = 1'b0;
      return;
    end
    cur_op = op;
    e = '{op: op, found: 1'b0, idx: 5'd0, key: 20'd0, val: 22'd0};
    case (op)
      3'd0: begin
        s = ref_search(key);
        e.found = (s >= 0);
        e.idx   = (s >= 0) ? 5'(s) : 5'd0;
      end
      3'd1: begin
        e.idx = idx;
        e.key = ref_key[idx];
        e.val = ref_val[idx];
      end
      3'd2: begin
        e.idx = idx;
        ref_key[idx] = key;
        ref_val[idx] = val;
        wq.push_back('{idx: idx, key: key, val: val});
      end
      3'd3: begin
        e.idx = exp_rand(cyc + 1);
        ref_key[e.idx] = key;
        ref_val[e.idx] = val;
        wq.push_back('{idx: e.idx, key: key, val: val});
      end
      3'd4: begin
        e.idx = 5'd31;
        for (int i = 0; i < 32; i++) begin
          ref_key[i] = INV;
          ref_val[i] = '0;
          wq.push_back('{idx: 5'(i), key: INV, val: 22'd0});
        end
      end
      default: ;
    endcase
    rq.push_back(e);
    rsp_exp++;
    @(posedge clock);
    #1;
    cmdValid = 1'b0;
    cmdOp    = 3'($urandom);
    if (op <= 3'd3) begin
      @(negedge clock);
      chk("exec_stall", 32'(translateStall), 32'(op == 3'd0));
      chk("exec_search_key", 32'(keySearchKey), 32'((op == 3'd0) ? key : translateKey));
      chk("exec_cmd_ready", 32'(cmdReady), 32'd0);
      if (op == 3'd0) begin
        @(negedge clock);
        chk("stall_after_exec", 32'(translateStall), 32'd0);
      end
    end
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (rsp_seen != rsp_exp && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("rsp_timeout", 32'(rsp_seen == rsp_exp), 32'd1);
  endtask

  initial begin : main
    logic [19:0] old_key[32];
    logic [21:0] old_val[32];
    int          n;
    int          j;
    resetN   = 1'b0;
    tb_load  = 1'b1;
    cmdValid = 1'b0;
    cmdOp    = '0;
    cmdIndex = '0;
    cmdKey   = '0;
    cmdValue = '0;
    for (int i = 0; i < 32; i++) begin
      ref_key[i] = rand_key();
      ref_val[i] = 22'($urandom);
    end
    repeat (2) @(posedge clock);
    #1 tb_load = 1'b0;
    @(negedge clock);
    chk("reset_cmd_ready", 32'(cmdReady), 32'd1);
    chk("reset_rsp_valid", 32'(rspValid), 32'd0);
    chk("reset_rsp_fields", 32'({rspFound, rspIndex, rspKey, rspValue} != '0), 32'd0);
    chk("reset_we", 32'({keyWriteEnable, valueWriteEnable}), 32'd0);
    chk("reset_random", 32'(randomIndex), 32'd31);
    resetN = 1'b1;
    @(negedge clock);
    chk("random_step1", 32'(randomIndex), 32'd30);
    @(negedge clock);
    chk("random_step2", 32'(randomIndex), 32'd29);

    send(3'd2, 5'd7, 20'h12345, 22'h2ABCDE); wait_rsp();
    send(3'd1, 5'd7, 20'h0, 22'h0);          wait_rsp();
    send(3'd2, 5'd20, 20'h12345, 22'h1);     wait_rsp();
    send(3'd0, 5'd0, 20'h12345, 22'h0);      wait_rsp();
    send(3'd0, 5'd0, 20'h55555, 22'h0);      wait_rsp();
    send(3'd6, 5'd3, 20'h12345, 22'h0);      wait_rsp();

    n = 0;
    while (!(cmdReady && randomIndex == 5'd10) && n < 100) begin
      @(negedge clock);
      n++;
    end
    send(3'd3, 5'd0, 20'hABCDE, 22'h13579); wait_rsp();
    send(3'd1, 5'd9, 20'h0, 22'h0);         wait_rsp();

    for (int k = 0; k < 200; k++) begin
      send(3'd3, 5'($urandom), rand_key(), 22'($urandom));
      wait_rsp();
      if ($urandom_range(0, 1) == 1) begin
        j = $urandom_range(0, 5);
        case (j)
          0, 1: send(3'd0, 5'd0, ($urandom_range(0, 1) == 1) ? ref_key[$urandom_range(0, 31)] : rand_key(), 22'd0);
          2:    send(3'd1, 5'($urandom), 20'd0, 22'd0);
          3:    send(3'd2, 5'($urandom), rand_key(), 22'($urandom));
          default: send(3'($urandom_range(5, 7)), 5'($urandom), 20'($urandom), 22'd0);
        endcase
        wait_rsp();
      end
    end

    hold_low = 1'b1;
    send(3'd4, 5'd0, 20'd0, 22'd0);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!rspValid && n < 100);
    chk("flush_cycles", 32'(n), 32'd33);
    chk("flush_writes_done", 32'(wq.size()), 32'd0);
    repeat (5) begin
      @(negedge clock);
      chk("held_rsp_valid", 32'(rspValid), 32'd1);
      chk("held_rsp_index", 32'(rspIndex), 32'd31);
      chk("held_cmd_ready", 32'(cmdReady), 32'd0);
    end
    hold_low = 1'b0;
    wait_rsp();
    send(3'd0, 5'd0, 20'h12345, 22'h0); wait_rsp();

    for (int i = 0; i < 32; i++) begin
      send(3'd2, 5'(i), rand_key(), 22'($urandom));
      wait_rsp();
    end
    for (int i = 0; i < 32; i++) begin
      old_key[i] = ref_key[i];
      old_val[i] = ref_val[i];
    end
    send(3'd4, 5'd0, 20'd0, 22'd0);
    n = 0;
    while (!(keyWriteEnable && keyAccessIndex == 5'd9) && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("flush_reached_9", 32'(keyAccessIndex), 32'd9);
    @(posedge clock);
    #1 resetN = 1'b0;
    for (int i = 10; i < 32; i++) begin
      ref_key[i] = old_key[i];
      ref_val[i] = old_val[i];
    end
    wq.delete();
    void'(rq.pop_back());
    rsp_exp--;
    @(negedge clock);
    chk("midreset_we", 32'({keyWriteEnable, valueWriteEnable}), 32'd0);
    @(negedge clock);
    chk("midreset_cmd_ready", 32'(cmdReady), 32'd1);
    chk("midreset_rsp_valid", 32'(rspValid), 32'd0);
    chk("midreset_rsp_index", 32'(rspIndex), 32'd0);
    resetN = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 32; i++) begin
      send(3'd1, 5'(i), 20'd0, 22'd0);
      wait_rsp();
    end

    repeat (3) @(negedge clock);
    chk("queues_drained", 32'(rq.size() + wq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tlb_op_controller.md
Name: tlb_op_controller

Overview:
- Sequences management operations on the 32-entry TLB: probe, indexed read, indexed write, random write and invalidate-all.
- Drives the TLB key memory (20-bit page keys, async read, sync write, combinational search with lowest-index priority) and a parallel 22-bit value memory.
- Sits between the CPU's TLB-instruction unit (command/response handshake) and the TLB storage.
- Shares the key-memory search port with the address-translation path.

Parameters:
- FIXED_ENTRIES, 4, entries 0..FIXED_ENTRIES-1 are never chosen by random write; legal range 1..30.
- INVALID_KEY, 20'hC0000, key written by invalidate-all; this page number is never presented for translation.

Ports:
- clock  in  1  system clock
- resetN  in  1  synchronous reset, active-low
- cmdValid  in  1  command present
- cmdReady  out  1  command accepted when cmdValid&&cmdReady
- cmdOp  in  3  0=probe, 1=readIndexed, 2=writeIndexed, 3=writeRandom, 4=invalidateAll; 5..7 reserved
- cmdIndex  in  5  entry index for read/write indexed
- cmdKey  in  20  probe key / key to write
- cmdValue  in  22  value to write
- rspValid  out  1  response present
- rspReady  in  1  response consumed when rspValid&&rspReady
- rspFound  out  1  probe hit
- rspIndex  out  5  probe hit index / index read or written
- rspKey  out  20  key read (readIndexed)
- rspValue  out  22  value read (readIndexed)
- translateKey  in  20  translation-path search key
- translateStall  out  1  translation search port stolen this cycle
- keyAccessIndex  out  5  key memory index
- keyReadValue  in  20  key memory async read data
- keyWriteValue  out  20  key memory write data
- keyWriteEnable  out  1  key memory write strobe
- keySearchKey  out  20  key memory search key
- keyFound  in  1  search hit
- keyFoundIndex  in  5  search hit index
- valueAccessIndex  out  5  value memory index (always equal to keyAccessIndex)
- valueReadValue  in  22  value memory async read data
- valueWriteValue  out  22  value memory write data
- valueWriteEnable  out  1  value memory write strobe
- randomIndex  out  5  current random register

Behaviour:
- States: IDLE, EXEC, FLUSH, RESP.
  - Reset (resetN=0 at clock edge) → IDLE from any state, including mid-FLUSH; no further writes occur. The flush is not completed; the memory is left partially flushed.
  - Reset output values: cmdReady=1, rspValid=0, all rsp* = 0, write enables 0, randomIndex=31, flush counter 0.
- cmdReady=1 only in IDLE.
- Acceptance in IDLE latches op, index, key and value into registers.
  - Ops 0..3 → EXEC.
  - Op 4 → FLUSH.
  - Ops 5..7 → RESP with rspFound=0 and rspIndex=0; no memory access.
- EXEC (exactly one cycle), using the latched fields:
  - probe: keySearchKey=latched key, translateStall=1. Capture rspFound=keyFound. rspIndex=keyFoundIndex on hit, 0 on miss.
  - readIndexed: access index=cmdIndex. Capture rspKey=keyReadValue, rspValue=valueReadValue, rspIndex=cmdIndex.
  - writeIndexed: access index=cmdIndex; both write enables=1. rspIndex=cmdIndex.
  - writeRandom: access index=randomIndex value during EXEC; both write enables=1. rspIndex=that value.
  - All ops → RESP.
- FLUSH:
  - Counter 0..31, one entry per cycle: keyWriteValue=INVALID_KEY, valueWriteValue=0, both write enables=1.
  - After writing entry 31 → RESP with rspIndex=31.
  - Total 32 cycles; translateStall=0 throughout.
- RESP: rspValid=1; rsp* held stable until rspValid&&rspReady → IDLE. Earliest next accept is one cycle later.
- Outside probe-EXEC: keySearchKey=translateKey, translateStall=0.
- Write enables are 1 only in EXEC (write ops) and FLUSH.
- Random register: updates every cycle regardless of state. If value==FIXED_ENTRIES, next value is 31; otherwise decrement. Sequence from reset: 31, 30, …, FIXED_ENTRIES, 31, …
- A write at index i makes the new key visible to a search or read the cycle after EXEC, not within EXEC.

Test Plan:
- Reset: hold resetN=0 for 2 cycles → cmdReady=1, rspValid=0, randomIndex=31; then randomIndex reads 30, 29 on the next cycles; after FIXED_ENTRIES=4 it reads 31.
- writeIndexed idx=7, key=0x12345, value=0x2ABCDE → RESP with rspIndex=7. Then readIndexed 7 → rspKey=0x12345, rspValue=0x2ABCDE.
- Probe 0x12345 with the same key also at idx 20 → rspFound=1, rspIndex=7, translateStall=1 for exactly one cycle. Probe 0x55555 → rspFound=0, rspIndex=0.
- writeRandom accepted when randomIndex=9 at EXEC → entry 9 written, rspIndex=9. Repeat 200 random writes → no write ever to index <4.
- invalidateAll → 32 consecutive write cycles, indices 0..31, key 0xC0000. Then probe 0x12345 → miss. Hold rspReady=0 for 5 cycles → rspValid and rspIndex=31 held stable, cmdReady=0.
- Assert resetN=0 at flush index 10 → entries 0..9 invalidated, 10..31 unchanged (checked via readIndexed), controller in IDLE.
